uart_tx_arbiter: RTL

Round-robin, packet-aware arbiter that lets NUM_REQ independent byte sources share the single UART transmitter inside the UART controller. It sits in the core clock domain between client logic and the transmitter's parallel input (tx_input_data / tx_input_data_valid / tx_output_ready). It holds the grant for a whole packet (up to req_last), paces bytes with the transmitter's ready handshake, and aborts stalled transfers with a timeout.

---
 rtl/uart_tx_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin, packet-aware arbiter sharing one UART transmitter between
//   NUM_REQ byte sources. A grant is held from the first byte of a packet up
//   to the byte flagged last. Bytes are paced by the transmitter's ready
//   level, which is asynchronous and resynchronised here. A transfer stalled
//   in LOAD or NEXT for TIMEOUT_CYC cycles is abandoned.
//
// Ports
//   clk, rstn      core clock, asynchronous active-low reset
//   req_valid      per-requester byte valid
//   req_data       byte of requester i at [8i+7:8i]
//   req_last       byte is the last of its packet
//   req_ready      byte accepted this cycle (combinational, at most one bit)
//   tx_data        byte presented to the transmitter
//   tx_data_valid  byte valid to the transmitter
//   tx_ready       transmitter idle / can accept (asynchronous to clk)
//   grant_id       current / last granted requester
//   busy           arbiter not idle
//   timeout_err    one-cycle pulse when a transfer is abandoned
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [8*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_data_valid,
  input  logic                         tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_NEXT
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rdy_s;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   tout_q, tout_d;

  logic                   found;
  logic [IDW-1:0]         win;
  int unsigned            idx;
  logic [7:0]             req_bytes [NUM_REQ];
  logic                   expired;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (32'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // Ready synchroniser: shift tx_ready in at bit 0, decide on the oldest bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(tx_ready);
    end
  end

  assign rdy_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign expired = (timer_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    tout_d    = 1'b0;
    req_ready = '0;

    unique case (state_q)
      S_IDLE: begin
        if (rdy_s && found) begin
          req_ready[win] = 1'b1;
          data_d         = req_bytes[win];
          last_d         = req_last[win];
          grant_d        = win;
          valid_d        = 1'b1;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        // A low synchronised ready means the transmitter has taken the byte;
        // that wins over a coincident timeout.
        if (!rdy_s) begin
          valid_d = 1'b0;
          state_d = S_DONE;
        end else if (expired) begin
          valid_d  = 1'b0;
          tout_d   = 1'b1;
          rr_ptr_d = next_id(grant_q);
          state_d  = S_IDLE;
        end
      end
      S_DONE: begin
        if (rdy_s) begin
          if (last_q) begin
            rr_ptr_d = next_id(grant_q);
            state_d  = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        req_ready[grant_q] = req_valid[grant_q];
        if (req_valid[grant_q]) begin
          data_d  = req_bytes[grant_q];
          last_d  = req_last[grant_q];
          valid_d = 1'b1;
          state_d = S_LOAD;
        end else if (expired) begin
          tout_d   = 1'b1;
          rr_ptr_d = next_id(grant_q);
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Timer restarts on every state entry and only runs in LOAD and NEXT.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == S_LOAD || state_q == S_NEXT) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      timer_q  <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      tout_q   <= tout_d;
    end
  end

  assign tx_data       = data_q;
  assign tx_data_valid = valid_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = tout_q;

endmodule
